// File: rtl/fft_pkg.sv
// Shared FFT constants, the index bit-reversal helper and the reorder read-FSM states.
package fft_pkg;

  localparam int unsigned FFT_N     = 16;
  localparam int unsigned FFT_LOG2N = 4;
  localparam int unsigned FFT_W     = 16;

  typedef enum logic {
    RD_IDLE,
    RD_STREAM
  } rd_state_e;

  // Reverses the low 'bits' bits of v; bits above are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int unsigned bits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < bits) r[5'(bits - 1 - i)] = v[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One N x 2W reorder bank: synchronous write port, combinational read port.
module fft_reorder_bank #(
  parameter int unsigned N     = 16,
  parameter int unsigned LOG2N = 4,
  parameter int unsigned W     = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [2*W-1:0]   wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [2*W-1:0]   rdata
);

  logic [2*W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output stream in, natural bin order out.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int unsigned N     = FFT_N,
  parameter int unsigned LOG2N = FFT_LOG2N,
  parameter int unsigned W     = FFT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_push,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_imag,
  output logic         in_stall,
  output logic         out_push,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_imag,
  input  logic         out_stall
);

  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
  rd_state_e        state_q, state_d;
  logic             out_push_q, out_push_d;
  logic [W-1:0]     out_real_q, out_real_d;
  logic [W-1:0]     out_imag_q, out_imag_d;

  logic             wr_fire;
  logic [1:0]       bank_we;
  logic [LOG2N-1:0] wr_addr;
  logic [LOG2N-1:0] rd_addr;
  logic [2*W-1:0]   wr_data;
  logic [2*W-1:0]   rd_data;
  logic [2*W-1:0]   bank_rdata [2];
  logic             load;
  logic             rd_release;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_reorder_bank #(.N(N), .LOG2N(LOG2N), .W(W)) u_bank (
      .clk   (clk),
      .we    (bank_we[b]),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (rd_addr),
      .rdata (bank_rdata[b])
    );
  end

  assign in_stall = full_q[wr_bank_q];
  assign wr_fire  = in_push & ~full_q[wr_bank_q];
  assign wr_addr  = LOG2N'(bitrev(32'(wr_cnt_q), LOG2N));
  assign wr_data  = {in_real, in_imag};
  assign bank_we  = {wr_fire & wr_bank_q, wr_fire & ~wr_bank_q};
  assign rd_data  = bank_rdata[rd_bank_q];

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    state_d    = state_q;
    out_push_d = out_push_q;
    out_real_d = out_real_q;
    out_imag_d = out_imag_q;
    rd_addr    = '0;
    load       = 1'b0;
    rd_release = 1'b0;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == LAST) wr_bank_d = ~wr_bank_q;
    end

    unique case (state_q)
      RD_IDLE: begin
        if (full_q[rd_bank_q]) begin
          load     = 1'b1;
          rd_cnt_d = LOG2N'(1);
          state_d  = RD_STREAM;
        end
      end
      RD_STREAM: begin
        if (!out_stall) begin
          if (rd_cnt_q != '0) begin
            load    = 1'b1;
            rd_addr = rd_cnt_q;
            if (rd_cnt_q == LAST) begin
              rd_release = 1'b1;
              rd_bank_d  = ~rd_bank_q;
              rd_cnt_d   = '0;
            end else begin
              rd_cnt_d = rd_cnt_q + LOG2N'(1);
            end
          end else if (full_q[rd_bank_q]) begin
            load     = 1'b1;
            rd_cnt_d = LOG2N'(1);
          end else begin
            out_push_d = 1'b0;
            state_d    = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    if (load) begin
      out_push_d = 1'b1;
      out_real_d = rd_data[2*W-1:W];
      out_imag_d = rd_data[W-1:0];
    end

    // Release and completion always hit different banks, so both updates apply.
    full_d = full_q;
    if (rd_release) full_d[rd_bank_q] = 1'b0;
    if (wr_fire && (wr_cnt_q == LAST)) full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      state_q    <= RD_IDLE;
      out_push_q <= 1'b0;
      out_real_q <= '0;
      out_imag_q <= '0;
    end else begin
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      state_q    <= state_d;
      out_push_q <= out_push_d;
      out_real_q <= out_real_d;
      out_imag_q <= out_imag_d;
    end
  end

  assign out_push = out_push_q;
  assign out_real = out_real_q;
  assign out_imag = out_imag_q;

endmodule
